// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD read/write drivers:
// read FSM states, bus constants and default bus timing in clock cycles.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_E_LOW  = 3'd3,
        ST_DONE   = 3'd4
    } lcd_rd_state_e;

    localparam int   LCD_BF_BIT      = 7;
    localparam logic LCD_MODE_STATUS = 1'b0;
    localparam logic LCD_MODE_DATA   = 1'b1;

    // Defaults sized for a 50 MHz system clock.
    localparam int LCD_T_AS     = 3;
    localparam int LCD_T_PW     = 24;
    localparam int LCD_T_EL     = 25;
    localparam int LCD_POLL_MAX = 65535;
    localparam int LCD_PHASE_W  = 16;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that saturates at zero; zero_o marks the last
// cycle of the current bus phase.
module lcd_phase_timer
    import lcd_pkg::*;
#(
    parameter int W = LCD_PHASE_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// LCD read-cycle engine: fetches busy flag/address or a data byte and can
// poll the busy flag until the controller is ready or a poll limit is hit.
module lcd_status_reader
    import lcd_pkg::*;
#(
    parameter int T_AS     = LCD_T_AS,
    parameter int T_PW     = LCD_T_PW,
    parameter int T_EL     = LCD_T_EL,
    parameter int POLL_MAX = LCD_POLL_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       wait_ready,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       lcd_oe,
    output logic       ready,
    output logic       done,
    output logic       timeout,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic [7:0] rd_data
);

    lcd_rd_state_e state_q;
    logic          mode_q;
    logic          wait_q;
    logic [15:0]   poll_q;
    logic          lcd_rs_q, lcd_rw_q, lcd_e_q, lcd_oe_q;
    logic          ready_q, done_q, timeout_q, busy_flag_q;
    logic [6:0]    addr_q;
    logic [7:0]    rd_data_q;

    logic                   tmr_zero_s;
    logic                   tmr_load_d;
    logic [LCD_PHASE_W-1:0] tmr_val_d;
    logic [16:0]            poll_inc_s;
    logic                   under_max_s;
    logic                   repoll_s;
    logic                   limit_s;

    assign poll_inc_s  = {1'b0, poll_q} + 17'd1;
    assign under_max_s = (poll_inc_s < 17'(POLL_MAX));
    assign repoll_s    = wait_q & busy_flag_q & under_max_s;
    assign limit_s     = wait_q & busy_flag_q & ~under_max_s;

    // Reload the phase timer on every state entry with that phase's length.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = LCD_PHASE_W'(T_AS - 1);
                end else begin
                    tmr_load_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_zero_s) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = LCD_PHASE_W'(T_PW - 1);
                end else begin
                    tmr_load_d = 1'b0;
                end
            end
            ST_E_HIGH: begin
                if (tmr_zero_s) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = LCD_PHASE_W'(T_EL - 1);
                end else begin
                    tmr_load_d = 1'b0;
                end
            end
            ST_E_LOW: begin
                if (tmr_zero_s && repoll_s) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = LCD_PHASE_W'(T_AS - 1);
                end else begin
                    tmr_load_d = 1'b0;
                end
            end
            default: begin
                tmr_load_d = 1'b0;
            end
        endcase
    end

    lcd_phase_timer #(
        .W(LCD_PHASE_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .zero_o     (tmr_zero_s)
    );

    // Read-cycle sequencer with registered pin and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= LCD_MODE_STATUS;
            wait_q      <= 1'b0;
            poll_q      <= 16'd0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_oe_q    <= 1'b1;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_flag_q <= 1'b0;
            addr_q      <= 7'd0;
            rd_data_q   <= 8'd0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_SETUP;
                        mode_q   <= mode;
                        wait_q   <= wait_ready & ~mode;
                        poll_q   <= 16'd0;
                        ready_q  <= 1'b0;
                        lcd_oe_q <= 1'b0;
                        lcd_rw_q <= 1'b1;
                        lcd_rs_q <= mode;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero_s) begin
                        state_q <= ST_E_HIGH;
                        lcd_e_q <= 1'b1;
                    end
                end
                ST_E_HIGH: begin
                    if (tmr_zero_s) begin
                        state_q <= ST_E_LOW;
                        lcd_e_q <= 1'b0;
                        if (mode_q == LCD_MODE_DATA) begin
                            rd_data_q <= lcd_data_in;
                        end else begin
                            busy_flag_q <= lcd_data_in[LCD_BF_BIT];
                            addr_q      <= lcd_data_in[6:0];
                        end
                    end
                end
                ST_E_LOW: begin
                    if (tmr_zero_s) begin
                        if (repoll_s) begin
                            state_q <= ST_SETUP;
                            poll_q  <= poll_q + 16'd1;
                        end else begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            timeout_q <= limit_s;
                            lcd_rw_q  <= 1'b0;
                            lcd_rs_q  <= 1'b0;
                            lcd_oe_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    lcd_e_q  <= 1'b0;
                    lcd_rw_q <= 1'b0;
                    lcd_rs_q <= 1'b0;
                    lcd_oe_q <= 1'b1;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = lcd_rw_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_oe    = lcd_oe_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign busy_flag = busy_flag_q;
    assign addr      = addr_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader: default bus timing, poll limit of 4,
// and a small LCD model returning a per-E-pulse response table.
module tb_lcd_status_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic       wait_ready;
    logic [7:0] lcd_data_in = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_oe;
    logic       ready, done, timeout, busy_flag;
    logic [6:0] addr;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] resp [0:7];
    int   pulse_cnt    = 0;
    int   pulse_base   = 0;
    int   e_w          = 0;
    int   e_width_last = 0;
    int   oe_viol      = 0;
    int   rs_viol      = 0;
    logic e_prev       = 1'b0;
    logic exp_rs       = 1'b0;

    lcd_status_reader #(
        .T_AS(3), .T_PW(24), .T_EL(25), .POLL_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .wait_ready(wait_ready), .lcd_data_in(lcd_data_in),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_oe(lcd_oe),
        .ready(ready), .done(done), .timeout(timeout),
        .busy_flag(busy_flag), .addr(addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // LCD model and bus monitor: drives DB on each E rise, tracks pulse widths.
    always @(negedge clk) begin
        int idx;
        if (lcd_e && !e_prev) begin
            idx = pulse_cnt - pulse_base;
            if (idx > 7) idx = 7;
            lcd_data_in = resp[idx];
            pulse_cnt++;
            e_w = 0;
        end
        if (lcd_e) e_w++;
        if (!lcd_e && e_prev) e_width_last = e_w;
        if ((lcd_rw || lcd_e) && lcd_oe) oe_viol++;
        if (lcd_rw && (lcd_rs !== exp_rs)) rs_viol++;
        e_prev = lcd_e;
    end

    task automatic do_read(input logic m, input logic w, output int j, output logic to_at_done);
        @(negedge clk);
        mode = m; wait_ready = w; exp_rs = m; start = 1'b1;
        pulse_base = pulse_cnt;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (!done && j < 1000) begin
            @(negedge clk);
            j++;
        end
        to_at_done = timeout;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 1'b0; wait_ready = 1'b0;
        #3;
        checks++;
        if ({lcd_rs, lcd_rw, lcd_e, lcd_oe, ready, done, timeout, busy_flag} !== 8'b0001_1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00011000",
                     {lcd_rs, lcd_rw, lcd_e, lcd_oe, ready, done, timeout, busy_flag});
        end
        checks++;
        if (addr !== 7'h00 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: addr=%h rd_data=%h want 00/00", addr, rd_data);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_status_read;
        int j; logic to;
        for (int i = 0; i < 8; i++) resp[i] = 8'h8A;
        @(negedge clk);
        mode = 1'b0; wait_ready = 1'b0; exp_rs = 1'b0; start = 1'b1;
        pulse_base = pulse_cnt;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (lcd_rw !== 1'b1 || ready !== 1'b0 || lcd_oe !== 1'b0 || lcd_e !== 1'b0) begin
            errors++;
            $display("FAIL status_accept: rw=%b ready=%b oe=%b e=%b want 1 0 0 0", lcd_rw, ready, lcd_oe, lcd_e);
        end
        j = 0;
        while (!done && j < 1000) begin
            @(negedge clk);
            j++;
        end
        to = timeout;
        checks++;
        if (j != 52) begin errors++; $display("FAIL status_latency: got %0d want 52", j); end
        checks++;
        if (busy_flag !== 1'b1 || addr !== 7'h0A || to !== 1'b0) begin
            errors++;
            $display("FAIL status_value: bf=%b addr=%h to=%b want 1 0a 0", busy_flag, addr, to);
        end
        checks++;
        if (pulse_cnt - pulse_base != 1 || e_width_last != 24) begin
            errors++;
            $display("FAIL status_epulse: pulses=%0d width=%0d want 1 24", pulse_cnt - pulse_base, e_width_last);
        end
        checks++;
        if (lcd_rw !== 1'b0 || lcd_oe !== 1'b1) begin
            errors++;
            $display("FAIL status_release: rw=%b oe=%b want 0 1", lcd_rw, lcd_oe);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL status_ready: ready=%b done=%b want 1 0", ready, done);
        end
    endtask

    task automatic test_data_read;
        int j; logic to;
        for (int i = 0; i < 8; i++) resp[i] = 8'h41;
        rs_viol = 0;
        do_read(1'b1, 1'b1, j, to);
        checks++;
        if (j != 52) begin errors++; $display("FAIL data_latency: got %0d want 52", j); end
        checks++;
        if (rd_data !== 8'h41) begin errors++; $display("FAIL data_value: got %h want 41", rd_data); end
        checks++;
        if (busy_flag !== 1'b1 || addr !== 7'h0A) begin
            errors++;
            $display("FAIL data_keep_status: bf=%b addr=%h want 1 0a", busy_flag, addr);
        end
        checks++;
        if (rs_viol != 0 || pulse_cnt - pulse_base != 1) begin
            errors++;
            $display("FAIL data_rs: rs_viol=%0d pulses=%0d want 0 1", rs_viol, pulse_cnt - pulse_base);
        end
    endtask

    task automatic test_busy_wait;
        int j; logic to;
        resp[0] = 8'h85; resp[1] = 8'h85; resp[2] = 8'h85;
        for (int i = 3; i < 8; i++) resp[i] = 8'h05;
        do_read(1'b0, 1'b1, j, to);
        checks++;
        if (j != 208) begin errors++; $display("FAIL busy_latency: got %0d want 208", j); end
        checks++;
        if (pulse_cnt - pulse_base != 4) begin
            errors++;
            $display("FAIL busy_pulses: got %0d want 4", pulse_cnt - pulse_base);
        end
        checks++;
        if (busy_flag !== 1'b0 || addr !== 7'h05 || to !== 1'b0) begin
            errors++;
            $display("FAIL busy_value: bf=%b addr=%h to=%b want 0 05 0", busy_flag, addr, to);
        end
    endtask

    task automatic test_timeout;
        int j; logic to;
        for (int i = 0; i < 8; i++) resp[i] = 8'hFF;
        do_read(1'b0, 1'b1, j, to);
        checks++;
        if (j != 208) begin errors++; $display("FAIL tmo_latency: got %0d want 208", j); end
        checks++;
        if (pulse_cnt - pulse_base != 4) begin
            errors++;
            $display("FAIL tmo_pulses: got %0d want 4", pulse_cnt - pulse_base);
        end
        checks++;
        if (to !== 1'b1 || busy_flag !== 1'b1 || addr !== 7'h7F) begin
            errors++;
            $display("FAIL tmo_value: to=%b bf=%b addr=%h want 1 1 7f", to, busy_flag, addr);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_len: got %b want 0", timeout); end
    endtask

    task automatic test_start_ignored;
        int j; int extra_done;
        for (int i = 0; i < 8; i++) resp[i] = 8'h33;
        @(negedge clk);
        mode = 1'b1; wait_ready = 1'b0; exp_rs = 1'b1; start = 1'b1;
        pulse_base = pulse_cnt;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (!done && j < 1000) begin
            @(negedge clk);
            j++;
            start = (j == 10 || j == 30) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        checks++;
        if (j != 52) begin errors++; $display("FAIL ignore_latency: got %0d want 52", j); end
        extra_done = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        checks++;
        if (pulse_cnt - pulse_base != 1 || extra_done != 0) begin
            errors++;
            $display("FAIL ignore_queue: pulses=%0d extra_done=%0d want 1 0", pulse_cnt - pulse_base, extra_done);
        end
        checks++;
        if (rd_data !== 8'h33) begin errors++; $display("FAIL ignore_value: got %h want 33", rd_data); end
    endtask

    task automatic test_reset_mid_read;
        int j;
        for (int i = 0; i < 8; i++) resp[i] = 8'h12;
        @(negedge clk);
        mode = 1'b0; wait_ready = 1'b1; exp_rs = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (!lcd_e && j < 100) begin
            @(negedge clk);
            j++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (lcd_e !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: e=%b want 1", lcd_e); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lcd_e !== 1'b0 || lcd_rw !== 1'b0 || done !== 1'b0 || lcd_oe !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: e=%b rw=%b done=%b oe=%b ready=%b want 0 0 0 1 1",
                     lcd_e, lcd_rw, done, lcd_oe, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        j = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done || lcd_e) j++;
        end
        checks++;
        if (j != 0 || busy_flag !== 1'b0 || addr !== 7'h00 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_after: activity=%0d bf=%b addr=%h rd=%h want 0 0 00 00", j, busy_flag, addr, rd_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        test_reset;
        test_status_read;
        test_data_read;
        test_busy_wait;
        test_timeout;
        test_start_ignored;
        test_reset_mid_read;
        checks++;
        if (oe_viol != 0) begin errors++; $display("FAIL oe_guard: violations=%0d want 0", oe_viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_status_reader.md
# lcd_status_reader

Read-side companion to the HD44780-style LCD write driver in the watch design. It runs LCD read cycles (RW=1) to fetch either the busy flag and address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1). It can poll the busy flag until it clears, so the write path can wait on real LCD readiness instead of fixed delays. The block sits beside the write driver; a top-level mux grants it the LCD pins while `ready`=0.

## Interface
Parameters:
- `T_AS`, default 3: cycles RS/RW are held stable before E rises (address setup); ≥1.
- `T_PW`, default 24: cycles E is held high; read data is sampled on the last of these; ≥2.
- `T_EL`, default 25: cycles E is held low after it falls, before the next access or bus release; ≥1.
- `POLL_MAX`, default 65535: maximum number of status reads per busy-wait request; ≥1, 16-bit counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only while `ready`=1.
- `mode`  in  1  0 = status read (RS=0), 1 = data read (RS=1); captured with `start`.
- `wait_ready`  in  1  status mode only: repeat reads until BF=0; captured with `start`.
- `lcd_data_in`  in  8  LCD DB[7:0] as seen on the input side of the pad.
- `lcd_rs`  out  1  register select.
- `lcd_rw`  out  1  1 = read.
- `lcd_e`  out  1  enable strobe.
- `lcd_oe`  out  1  1 = FPGA drives DB; 0 = DB released to the LCD.
- `ready`  out  1  idle, request accepted.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  one-cycle pulse coincident with `done` when the poll limit is hit.
- `busy_flag`  out  1  last sampled DB7 (status mode).
- `addr`  out  7  last sampled DB[6:0] (status mode).
- `rd_data`  out  8  last sampled DB[7:0] (data mode).

## Operation
- Reset values: `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `lcd_oe`=1, `ready`=1, `done`=0, `timeout`=0, `busy_flag`=0, `addr`=0, `rd_data`=0, poll count 0, state IDLE.
- FSM states: IDLE, SETUP, E_HIGH, E_LOW, DONE.
- IDLE: `ready`=1, RW=0, `lcd_oe`=1. When `start`=1, capture `mode` and `wait_ready` (`wait_ready` is forced to 0 when `mode`=1), clear the poll count, and go to SETUP.
- SETUP, T_AS cycles: `ready`=0, `lcd_oe`=0, `lcd_rw`=1, `lcd_rs`=mode, `lcd_e`=0.
- E_HIGH, T_PW cycles: `lcd_e`=1. On the final cycle, register `lcd_data_in`. Status mode updates `busy_flag` and `addr`; data mode updates `rd_data`. Outputs not belonging to the current mode keep their old values.
- E_LOW, T_EL cycles: `lcd_e`=0; RW, RS and `lcd_oe`=0 stay held. Exit conditions:
  - `wait_ready`=1, sampled BF=1 and poll count+1 < POLL_MAX: increment the poll count and go to SETUP.
  - BF=1 and poll count+1 = POLL_MAX: go to DONE with the timeout flag set.
  - Otherwise: go to DONE.
- DONE, 1 cycle: `done`=1 (`timeout`=1 if flagged), `lcd_rw`=0, `lcd_rs`=0, `lcd_oe`=1. Then go to IDLE.
- `start` while `ready`=0 is ignored; nothing is queued.
- With `wait_ready`=0, exactly one read is performed.
- Timing counter is a single phase down-counter, reloaded on every state entry.

## Timing
- `start` sampled high at edge k: `lcd_rw` rises at k; `lcd_e` rises at k+T_AS; `lcd_e` falls at k+T_AS+T_PW.
- `done` is high during cycle k+T_AS+T_PW+T_EL; `ready` returns 1 one cycle later.
- Each additional poll adds T_AS+T_PW+T_EL cycles.
- Sampled data is visible on the outputs from the cycle after the last E_HIGH cycle, and is stable when `done` pulses.
- `lcd_oe` is 0 for the entire period `lcd_rw`=1 and never drops while `lcd_e`=1 with RW=0. The bus is released one cycle before any E assertion and reclaimed only after T_EL.
- Reset mid-operation: all outputs take their reset values immediately (asynchronously), and no `done` is issued.
- Defaults meet HD44780 tAS ≥ 40 ns, PWEH ≥ 450 ns, tDDR ≤ 360 ns, and tcycE ≥ 1000 ns at 50 MHz.

## Structure
- Shared package `lcd_pkg`:
  - state enum;
  - constants `LCD_BF_BIT`=7, `LCD_MODE_STATUS`=0, `LCD_MODE_DATA`=1;
  - default timing parameters, shared with the write driver.
- One sub-module: `lcd_phase_timer`, a loadable down-counter with a zero flag.
- Pin mux/arbitration with the write driver lives at top level, not in this block.

## Test plan
- Reset asserted mid-E_HIGH → `lcd_e`, `lcd_rw` and `done` go 0 and `lcd_oe` goes 1 in the same cycle; outputs are 0 after release.
- Status read, `wait_ready`=0, model returns 0x8A → `done` at k+52 (defaults), `busy_flag`=1, `addr`=0x0A, one E pulse 24 cycles wide.
- Data read, `mode`=1, model returns 0x41 → `lcd_rs`=1 throughout, `rd_data`=0x41, `busy_flag`/`addr` unchanged.
- Busy-wait, model returns BF=1 for 3 reads then 0x05 → 4 E pulses, `done` at k+4·52, `busy_flag`=0, `addr`=0x05, `timeout`=0.
- Busy-wait, POLL_MAX=4, BF stuck at 1 → exactly 4 E pulses, `done`=`timeout`=1 in the same cycle, `busy_flag`=1.
- `start` pulsed during an active read → ignored, single E pulse. Across all scenarios, check `lcd_oe`=0 whenever `lcd_rw`=1 or `lcd_e`=1.
